// File: rtl/srm_pkg.sv
// rtl/srm_pkg.sv - ISA opcodes, register-select encodings and instruction field positions
package srm_pkg;

  typedef enum logic [2:0] {
    OP_B    = 3'b001,
    OP_BL   = 3'b010,
    OP_LDR  = 3'b011,
    OP_STR  = 3'b100,
    OP_ALU  = 3'b101,
    OP_MOV  = 3'b110,
    OP_HALT = 3'b111
  } opcode_t;

  localparam logic [1:0] SEL_RM   = 2'b00;
  localparam logic [1:0] SEL_RD   = 2'b01;
  localparam logic [1:0] SEL_RN   = 2'b10;
  localparam logic [1:0] SEL_ZERO = 2'b11;

  localparam int OP_HI  = 15;
  localparam int OP_LO  = 13;
  localparam int ALU_HI = 12;
  localparam int ALU_LO = 11;
  localparam int RN_HI  = 10;
  localparam int RN_LO  = 8;
  localparam int RD_HI  = 7;
  localparam int RD_LO  = 5;
  localparam int SH_HI  = 4;
  localparam int SH_LO  = 3;
  localparam int RM_HI  = 2;
  localparam int RM_LO  = 0;

  function automatic logic [2:0] reg_select(input logic [1:0] sel, input logic [15:0] instr);
    logic [2:0] r;
    r = 3'b000;
    case (sel)
      SEL_RM:  r = instr[RM_HI:RM_LO];
      SEL_RD:  r = instr[RD_HI:RD_LO];
      SEL_RN:  r = instr[RN_HI:RN_LO];
      default: r = 3'b000;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/instr_queue.sv
// rtl/instr_queue.sv - generic synchronous FIFO with flush; no pass-through when full
module instr_queue #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 2
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   flush,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [WIDTH-1:0]       in_data,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [WIDTH-1:0]       out_data,
  output logic [$clog2(DEPTH):0] count
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH) + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic             full;
  logic             push;
  logic             pop;

  assign full      = (count == CW'(DEPTH));
  assign in_ready  = !reset && !full && !flush;
  assign out_valid = (count != '0);
  assign out_data  = mem[rd_ptr];
  assign push      = in_valid && in_ready;
  // A pop coinciding with flush or reset is ignored; the queue empties anyway.
  assign pop       = out_valid && out_ready && !flush && !reset;

  function automatic logic [PW-1:0] ptr_next(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= in_data;
    end
  end

  always_ff @(posedge clk) begin
    if (reset || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= ptr_next(wr_ptr);
      end
      if (pop) begin
        rd_ptr <= ptr_next(rd_ptr);
      end
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/instr_decode_stage.sv
// rtl/instr_decode_stage.sv - buffered instruction decode stage; SRM_ILLEGAL_DETECT_EN adds illegal/illegal_seen
module instr_decode_stage
  import srm_pkg::*;
#(
  parameter int INSTR_W = 16,
  parameter int DATA_W  = 16,
  parameter int DEPTH   = 2
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   flush,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [INSTR_W-1:0]     in_instr,
  output logic                   out_valid,
  input  logic                   out_ready,
  input  logic [1:0]             rd_sel,
  input  logic [1:0]             wr_sel,
  output logic [2:0]             opcode,
  output logic [1:0]             ALUop,
  output logic [1:0]             shift,
  output logic [DATA_W-1:0]      sximm5,
  output logic [DATA_W-1:0]      sximm8,
  output logic [2:0]             readnum,
  output logic [2:0]             writenum,
  output logic [$clog2(DEPTH):0] count
`ifdef SRM_ILLEGAL_DETECT_EN
  ,
  output logic                   illegal,
  output logic                   illegal_seen
`endif
);

  logic [INSTR_W-1:0] q_data;
  logic               q_valid;
  logic [15:0]        head;

  instr_queue #(
    .WIDTH(INSTR_W),
    .DEPTH(DEPTH)
  ) u_queue (
    .clk      (clk),
    .reset    (reset),
    .flush    (flush),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_data  (in_instr),
    .out_valid(q_valid),
    .out_ready(out_ready),
    .out_data (q_data),
    .count    (count)
  );

  assign out_valid = q_valid && !reset;
  // Zeroing the head word makes every decoded field 0 when nothing is valid.
  assign head      = out_valid ? q_data[15:0] : 16'h0000;

  assign opcode   = head[OP_HI:OP_LO];
  assign ALUop    = head[ALU_HI:ALU_LO];
  assign shift    = head[SH_HI:SH_LO];
  assign sximm5   = DATA_W'($signed(head[4:0]));
  assign sximm8   = DATA_W'($signed(head[7:0]));
  assign readnum  = reg_select(rd_sel, head);
  assign writenum = reg_select(wr_sel, head);

`ifdef SRM_ILLEGAL_DETECT_EN
  logic illegal_pop;

  assign illegal     = out_valid && ((opcode == 3'b000) || ((opcode == OP_MOV) && ALUop[0]));
  assign illegal_pop = illegal && out_ready && !flush;

  // Sticky across flush so software can still see the event after a branch.
  always_ff @(posedge clk) begin
    if (reset) begin
      illegal_seen <= 1'b0;
    end else if (illegal_pop) begin
      illegal_seen <= 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_instr_decode_stage.sv
// tb/tb_instr_decode_stage.sv - scoreboard bench for instr_decode_stage; SRM_ILLEGAL_DETECT_EN checks illegal ports
module tb_instr_decode_stage;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        flush = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [15:0] in_instr = 16'h0000;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [1:0]  rd_sel = 2'b00;
  logic [1:0]  wr_sel = 2'b00;
  logic [2:0]  opcode;
  logic [1:0]  ALUop;
  logic [1:0]  shift;
  logic [15:0] sximm5;
  logic [15:0] sximm8;
  logic [2:0]  readnum;
  logic [2:0]  writenum;
  logic [1:0]  count;
  logic        illegal;
  logic        illegal_seen;

  int checks = 0;
  int failures = 0;
  logic [15:0] sb[$];
  bit seen_m = 1'b0;

  always #5 clk = ~clk;

  instr_decode_stage #(.INSTR_W(16), .DATA_W(16), .DEPTH(2)) dut (
    .clk(clk), .reset(reset), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr),
    .out_valid(out_valid), .out_ready(out_ready),
    .rd_sel(rd_sel), .wr_sel(wr_sel),
    .opcode(opcode), .ALUop(ALUop), .shift(shift),
    .sximm5(sximm5), .sximm8(sximm8),
    .readnum(readnum), .writenum(writenum), .count(count)
`ifdef SRM_ILLEGAL_DETECT_EN
    , .illegal(illegal), .illegal_seen(illegal_seen)
`endif
  );

`ifndef SRM_ILLEGAL_DETECT_EN
  assign illegal = 1'b0;
  assign illegal_seen = 1'b0;
`endif

  function automatic logic [2:0] reg_model(input logic [1:0] s, input logic [15:0] w);
    case (s)
      2'd0:    return w[2:0];
      2'd1:    return w[7:5];
      2'd2:    return w[10:8];
      default: return 3'd0;
    endcase
  endfunction

  // Checks every output against the scoreboard model, then advances one clock.
  task automatic tick();
    logic [15:0] h;
    logic [45:0] exp_dec, act_dec;
    bit vm, pu, po, ill;
    #1;
    vm = !reset && (sb.size() > 0);
    h = vm ? sb[0] : 16'h0000;
    checks++;
    if (in_ready !== (!reset && !flush && sb.size() < 2)) begin
      failures++; $display("FAIL in_ready: got %b want %b", in_ready, !reset && !flush && sb.size() < 2);
    end
    checks++;
    if (out_valid !== vm) begin
      failures++; $display("FAIL out_valid: got %b want %b", out_valid, vm);
    end
    checks++;
    if (count !== 2'(sb.size())) begin
      failures++; $display("FAIL count: got %0d want %0d", count, sb.size());
    end
    exp_dec = {h[15:13], h[12:11], h[4:3], {11{h[4]}}, h[4:0], {8{h[7]}}, h[7:0],
               reg_model(rd_sel, h), reg_model(wr_sel, h)};
    act_dec = {opcode, ALUop, shift, sximm5, sximm8, readnum, writenum};
    checks++;
    if (act_dec !== exp_dec) begin
      failures++; $display("FAIL decode head=%h: got %h want %h", h, act_dec, exp_dec);
    end
    ill = vm && (h[15:13] == 3'b000 || (h[15:13] == 3'b110 && h[11]));
`ifdef SRM_ILLEGAL_DETECT_EN
    checks++;
    if (illegal !== ill) begin
      failures++; $display("FAIL illegal: got %b want %b", illegal, ill);
    end
    checks++;
    if (illegal_seen !== seen_m) begin
      failures++; $display("FAIL illegal_seen: got %b want %b", illegal_seen, seen_m);
    end
`endif
    pu = in_valid && !reset && !flush && sb.size() < 2;
    po = vm && out_ready && !flush;
    @(posedge clk);
    if (reset) begin
      sb.delete();
      seen_m = 1'b0;
    end else if (flush) begin
      sb.delete();
    end else begin
      if (po) begin
        if (ill) seen_m = 1'b1;
        void'(sb.pop_front());
      end
      if (pu) sb.push_back(in_instr);
    end
    #2;
  endtask

  task automatic push_word(input logic [15:0] w);
    in_valid = 1'b1;
    in_instr = w;
    tick();
    in_valid = 1'b0;
  endtask

  task automatic drain();
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) tick();
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    in_valid = 1'b1;
    @(posedge clk); #2;
    tick();
    reset = 1'b0;
    in_valid = 1'b0;
    rd_sel = 2'b10;
    #1;
    checks++;
    if ({out_valid, count, opcode, sximm8, readnum} !== 25'd0) begin
      failures++; $display("FAIL reset_state: got v=%b c=%0d op=%b imm8=%h rn=%0d want zeros",
                           out_valid, count, opcode, sximm8, readnum);
    end
    tick();
  endtask

  task automatic test_mov();
    rd_sel = 2'b10;
    push_word(16'b1101_0001_0000_0111);
    checks++;
    if ({out_valid, opcode, readnum, sximm8} !== {1'b1, 3'b110, 3'd1, 16'h0007}) begin
      failures++; $display("FAIL mov: got v=%b op=%b rn=%0d imm8=%h want 1 110 1 0007",
                           out_valid, opcode, readnum, sximm8);
    end
    drain();
  endtask

  task automatic test_sign_ext();
    push_word(16'h10FF);
    checks++;
    if ({sximm8, sximm5} !== {16'hFFFF, 16'hFFFF}) begin
      failures++; $display("FAIL sext_ff: got imm8=%h imm5=%h want FFFF FFFF", sximm8, sximm5);
    end
    drain();
    push_word(16'h0010);
    checks++;
    if ({sximm8, sximm5} !== {16'h0010, 16'hFFF0}) begin
      failures++; $display("FAIL sext_10: got imm8=%h imm5=%h want 0010 FFF0", sximm8, sximm5);
    end
    drain();
  endtask

  task automatic test_sel();
    push_word(16'b101_01_011_110_00_001);
    for (int i = 0; i < 16; i++) begin
      rd_sel = 2'(i);
      wr_sel = 2'(i >> 2);
      tick();
    end
    checks++;
    if ({readnum, writenum} !== 6'd0) begin
      failures++; $display("FAIL sel_zero: got rn=%0d wn=%0d want 0 0", readnum, writenum);
    end
    rd_sel = 2'b00;
    wr_sel = 2'b01;
    drain();
  endtask

  task automatic test_fill_order();
    in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      in_instr = 16'hA100 + 16'(i);
      tick();
    end
    #1;
    checks++;
    if ({count, in_ready} !== {2'd2, 1'b0}) begin
      failures++; $display("FAIL fill: got count=%0d in_ready=%b want 2 0", count, in_ready);
    end
    in_valid = 1'b0;
    drain();
  endtask

  task automatic test_full_pop();
    push_word(16'h6A21);
    push_word(16'h8B42);
    in_valid = 1'b1;
    in_instr = 16'hE000;
    out_ready = 1'b1;
    tick();
    in_valid = 1'b0;
    out_ready = 1'b0;
    #1;
    checks++;
    if ({count, in_ready} !== {2'd1, 1'b1}) begin
      failures++; $display("FAIL full_pop: got count=%0d in_ready=%b want 1 1", count, in_ready);
    end
    drain();
  endtask

  task automatic test_back_to_back();
    in_valid = 1'b1;
    out_ready = 1'b1;
    for (int i = 0; i < 12; i++) begin
      in_instr = 16'($urandom);
      rd_sel = 2'($urandom_range(0, 3));
      tick();
    end
    in_valid = 1'b0;
    drain();
  endtask

  task automatic test_flush();
    push_word(16'hB3C4);
    push_word(16'h5D6E);
    flush = 1'b1;
    in_valid = 1'b1;
    out_ready = 1'b1;
    in_instr = 16'h7777;
    tick();
    flush = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b0;
    #1;
    checks++;
    if ({count, out_valid} !== 3'b000) begin
      failures++; $display("FAIL flush: got count=%0d out_valid=%b want 0 0", count, out_valid);
    end
    tick();
  endtask

  task automatic test_reset_mid();
    push_word(16'hC123);
    push_word(16'h0000);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    #1;
    checks++;
    if ({count, out_valid} !== 3'b000) begin
      failures++; $display("FAIL reset_mid: got count=%0d out_valid=%b want 0 0", count, out_valid);
    end
    tick();
  endtask

`ifdef SRM_ILLEGAL_DETECT_EN
  task automatic test_illegal();
    push_word(16'hD000);
    drain();
    push_word(16'h0000);
    #1;
    checks++;
    if ({illegal, illegal_seen} !== 2'b10) begin
      failures++; $display("FAIL illegal_pre: got %b%b want 10", illegal, illegal_seen);
    end
    drain();
    push_word(16'hC800);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    #1;
    checks++;
    if (illegal_seen !== 1'b1) begin
      failures++; $display("FAIL illegal_flush: got %b want 1", illegal_seen);
    end
    tick();
  endtask
`endif

  initial begin
    test_reset();
    test_mov();
    test_sign_ext();
    test_sel();
    test_fill_order();
    test_full_pop();
    test_back_to_back();
    test_flush();
`ifdef SRM_ILLEGAL_DETECT_EN
    test_illegal();
`endif
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
